// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_cmd_master
//  Description : Single-outstanding AXI4-Lite master. Turns a valid/ready
//                request stream into AXI4-Lite reads/writes and returns each
//                result on a valid/ready response stream, counting error
//                responses in a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_master #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    // request stream
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    // response stream
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [15:0]               err_cnt,
    // AXI4-Lite write address
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // AXI4-Lite write data
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // AXI4-Lite write response
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AXI4-Lite read address
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // AXI4-Lite read data
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    // Only 32- and 64-bit data paths are supported.
    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
            $error("axi4_lite_cmd_master: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WR_B = 3'd2,
        S_RD_A = 3'd3,
        S_RD_R = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic                      r_awvalid,   w_awvalid_nxt;
    logic                      r_wvalid,    w_wvalid_nxt;
    logic                      r_arvalid,   w_arvalid_nxt;
    logic                      r_bready,    w_bready_nxt;
    logic                      r_rready,    w_rready_nxt;
    logic                      r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]                r_rsp_resp,  w_rsp_resp_nxt;
    logic [15:0]               r_err_cnt,   w_err_cnt_nxt;

    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;

    logic                      w_capture;
    logic                      w_err_inc;

    // Next-state and next-output decode; everything defaults to "hold".
    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_arvalid_nxt   = r_arvalid;
        w_bready_nxt    = r_bready;
        w_rready_nxt    = r_rready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_capture       = 1'b0;
        w_err_inc       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_capture = 1'b1;
                    if (req_write) begin
                        w_state_nxt   = S_WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_RD_A;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; each valid drops after its ready.
                if (r_awvalid && m_axi_awready) w_awvalid_nxt = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid_nxt  = 1'b0;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_state_nxt  = S_WR_B;
                    w_bready_nxt = 1'b1;
                end
            end
            S_WR_B: begin
                if (m_axi_bvalid) begin
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_resp_nxt  = m_axi_bresp;
                    w_err_inc       = m_axi_bresp[1];
                    w_state_nxt     = S_RSP;
                end
            end
            S_RD_A: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (m_axi_rvalid) begin
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = m_axi_rdata;
                    w_rsp_resp_nxt  = m_axi_rresp;
                    w_err_inc       = m_axi_rresp[1];
                    w_state_nxt     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_err_cnt_nxt = r_err_cnt;
        if (w_err_inc && (r_err_cnt != 16'hFFFF)) begin
            w_err_cnt_nxt = r_err_cnt + 16'd1;
        end
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
            r_err_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
        end
    end

    // Request capture; held stable for the whole transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_capture) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    assign req_ready     = (r_state == S_IDLE) && !rst;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign err_cnt       = r_err_cnt;

    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = rst ? 3'b000 : PROT;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = rst ? 3'b000 : PROT;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire
